puf_uart_streamer: RTL

Consumes the 128-bit PUF response word and its done flag from the PUF response assembler (`puf128`). On a rising edge of the done flag it snapshots the word and serialises it off-chip as 16 UART 8N1 frames, so the lab host can log challenge/response pairs. It also holds the last capture so the host side can request a retransmission without re-running the PUF.

---
 rtl/puf_uart_streamer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/puf_uart_streamer.sv
// Snapshots the 128-bit PUF response on a rising done flag and sends it as 16 UART 8N1
// frames, most significant byte first; the last capture can be resent on request.
module puf_uart_streamer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] puf_out,
    input  logic         puf_done,
    input  logic         send_again,
    output logic         tx,
    output logic         busy,
    output logic         tx_done,
    output logic [4:0]   byte_idx,
    output logic         has_data
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_START   = 2'd1;
    localparam logic [1:0]  S_DATA    = 2'd2;
    localparam logic [1:0]  S_STOP    = 2'd3;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [1:0]   state;
    logic [15:0]  baud_cnt;
    logic [2:0]   bit_idx;
    logic [127:0] shadow;
    logic         puf_done_d;
    logic         rise;
    logic         bit_end;
    logic [7:0]   cur_byte;

    // Byte k lives at shadow[8*(15-k) +: 8]; 15-k is the 4-bit complement of k.
    always_comb begin
        rise     = puf_done & ~puf_done_d;
        bit_end  = (baud_cnt == BAUD_LAST);
        cur_byte = shadow[{~byte_idx[3:0], 3'b000} +: 8];
    end

    // Frame sequencer: every tx change is registered on the edge that starts the new bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            baud_cnt   <= 16'd0;
            bit_idx    <= 3'd0;
            shadow     <= 128'd0;
            puf_done_d <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            byte_idx   <= 5'd0;
            has_data   <= 1'b0;
        end else begin
            puf_done_d <= puf_done;
            tx_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= 16'd0;
                    bit_idx  <= 3'd0;
                    if (rise) begin
                        shadow   <= puf_out;
                        has_data <= 1'b1;
                        byte_idx <= 5'd0;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        state    <= S_START;
                    end else if (send_again && has_data) begin
                        byte_idx <= 5'd0;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        bit_idx  <= 3'd0;
                        tx       <= cur_byte[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        if (byte_idx == 5'd15) begin
                            byte_idx <= 5'd16;
                            busy     <= 1'b0;
                            tx_done  <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            // Back-to-back frames: next start bit begins on this edge.
                            byte_idx <= byte_idx + 5'd1;
                            tx       <= 1'b0;
                            state    <= S_START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
